fifo_rd_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO, sitting entirely in the `rd_clk` domain. It drains words from the FIFO read port (`rd_en`, `data_out`, `fifo_empty`) and presents them downstream on a valid/ready stream. A 2-entry skid buffer sustains one word per cycle under backpressure without losing data. An enable/flush state machine provides clean start and stop.

---
 rtl/fifo_rd_ctrl.sv | 92 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-side controller: 2-entry skid buffer, enable/flush FSM.
// Define FIFO_RD_CNT_EN to add the rd_count delivered-word counter.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8
`ifdef FIFO_RD_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_CNT_EN
  , output logic [CNT_WIDTH-1:0] rd_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  state_e state_q, state_d;
  logic [1:0] occ_q, occ_d;
  logic infl_q;
  logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic pop;
  logic tail;

  assign pop     = m_valid & m_ready;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[0];
  assign busy    = (state_q != IDLE);

  // occupancy after this cycle's capture and pop; gates the next FIFO pop
  assign occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};
  assign rd_en = (state_q == RUN) & ~fifo_empty & (occ_d < 2'd2);

  assign tail = (occ_q == 2'd2) | ((occ_q == 2'd1) & ~pop);

  always_comb begin
    buf_d = buf_q;
    if (pop) buf_d[0] = buf_q[1];
    if (infl_q) buf_d[tail] = data_out;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN:   if (!enable) state_d = FLUSH;
      FLUSH: begin
        if (enable) state_d = RUN;
        else if (!infl_q && occ_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      infl_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      infl_q  <= rd_en;
      buf_q   <= buf_d;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  assign rd_count = cnt_q;

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: queue-based reference model, source FIFO model,
// pop-order scoreboard, directed scenarios and a randomized run.
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rd_rst = 1'b1;
  logic enable = 1'b0;
  logic fifo_empty = 1'b1;
  logic m_ready = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic rd_en, m_valid, busy;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [CW-1:0] rd_count;
`endif

  always #5 clk = ~clk;

`ifdef FIFO_RD_CNT_EN
  fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
`else
  fifo_rd_ctrl #(.DATA_WIDTH(DW)) dut (
`endif
    .rd_clk(clk),
    .rd_rst(rd_rst),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .data_out(data_out),
    .rd_en(rd_en),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .busy(busy)
`ifdef FIFO_RD_CNT_EN
    , .rd_count(rd_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic fe = 1'b0;
  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_order[$];
  logic [DW-1:0] mq[$];
  int mst = 0;
  int minfl = 0;
  int mcnt = 0;

  bit ln_rd[$];
  bit ln_v[$];
  bit ln_b[$];
  bit ln_p[$];
  logic [DW-1:0] ln_d[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic mreset();
    mst = 0;
    mq.delete();
    minfl = 0;
    mcnt = 0;
    exp_order.delete();
  endtask

  task automatic clr_logs();
    ln_rd.delete();
    ln_v.delete();
    ln_b.delete();
    ln_p.delete();
    ln_d.delete();
  endtask

  task automatic cycle();
    int mpop, erd, ns;
    bit p_rd, p_pop, p_en;
    logic [DW-1:0] p_data, p_dout;
    fifo_empty = (src.size() == 0) || fe;
    #1;
    mpop = (mq.size() != 0 && m_ready) ? 1 : 0;
    erd = (mst == 1 && !fifo_empty &&
           int'(mq.size()) + minfl - mpop < 2) ? 1 : 0;
    chk("rd_en", 32'(rd_en), 32'(erd));
    chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    chk("busy", 32'(busy), 32'(mst != 0));
    if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
`ifdef FIFO_RD_CNT_EN
    chk("rd_count", 32'(rd_count), 32'(mcnt));
`endif
    ln_rd.push_back(rd_en);
    ln_v.push_back(m_valid);
    ln_b.push_back(busy);
    ln_p.push_back(m_valid & m_ready);
    ln_d.push_back(m_data);
    p_rd = rd_en;
    p_pop = m_valid & m_ready;
    p_data = m_data;
    p_dout = data_out;
    p_en = enable;
    @(posedge clk);
    #1;
    if (!rd_rst) begin
      mreset();
    end else begin
      if (p_pop) begin
        if (exp_order.size() == 0) fail_now("order_extra_word");
        else chk("order", 32'(p_data), 32'(exp_order.pop_front()));
      end
      case (mst)
        0: ns = p_en ? 1 : 0;
        1: ns = p_en ? 1 : 2;
        default: ns = p_en ? 1 : ((minfl == 0 && mq.size() == 0) ? 0 : 2);
      endcase
      if (mpop == 1) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % (1 << CW);
      end
      if (minfl == 1) mq.push_back(p_dout);
      if (mq.size() > 2) fail_now("model_occ_over_2");
      minfl = erd;
      mst = ns;
      if (p_rd) begin
        if (src.size() == 0) begin
          fail_now("pop_of_empty_fifo");
        end else begin
          data_out = src.pop_front();
          exp_order.push_back(data_out);
        end
      end
    end
  endtask

  task automatic do_reset(input bit clr);
    rd_rst = 1'b0;
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
`ifdef FIFO_RD_CNT_EN
    chk("rst_rd_count", 32'(rd_count), 32'(0));
`endif
    mreset();
    if (clr) begin
      src.delete();
      data_out = '0;
    end
    enable = 1'b0;
    m_ready = 1'b0;
    fe = 1'b0;
    repeat (2) cycle();
    rd_rst = 1'b1;
  endtask

  function automatic int count_ones(input int lo, input int hi, input int which);
    int n = 0;
    for (int i = lo; i <= hi && i < ln_p.size(); i++) begin
      case (which)
        0: n += ln_rd[i];
        default: n += ln_p[i];
      endcase
    end
    return n;
  endfunction

  initial begin
    int first;
    #2;
    do_reset(1'b1);

    // three words with m_ready high
    src = '{8'h00, 8'h03, 8'h06};
    enable = 1'b1;
    m_ready = 1'b1;
    clr_logs();
    repeat (8) cycle();
    chk("t1_rd_en_c0", 32'(ln_rd[0]), 32'(0));
    chk("t1_rd_en_run", 32'(count_ones(1, 3, 0)), 32'(3));
    chk("t1_rd_en_c4", 32'(ln_rd[4]), 32'(0));
    chk("t1_valid_run", 32'(ln_v[3] & ln_v[4] & ln_v[5]), 32'(1));
    chk("t1_data0", 32'(ln_d[3]), 32'(8'h00));
    chk("t1_data1", 32'(ln_d[4]), 32'(8'h03));
    chk("t1_data2", 32'(ln_d[5]), 32'(8'h06));
    chk("t1_valid_end", 32'(ln_v[6]), 32'(0));

    // backpressure: 8 words, ready low for 10 cycles
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) src.push_back(DW'(8'h10 + i));
    enable = 1'b1;
    clr_logs();
    repeat (10) cycle();
    chk("t2_rd_en_pulses", 32'(count_ones(0, 9, 0)), 32'(2));
    chk("t2_hold_valid", 32'(ln_v[9]), 32'(1));
    chk("t2_hold_data", 32'(ln_d[9]), 32'(8'h10));
    m_ready = 1'b1;
    clr_logs();
    repeat (12) cycle();
    chk("t2_no_gaps", 32'(count_ones(0, 7, 1)), 32'(8));
    for (int i = 0; i < 8; i++) chk("t2_seq", 32'(ln_d[i]), 32'(8'h10 + i));
    chk("t2_done", 32'(ln_p[8]), 32'(0));

    // fifo_empty toggling every other cycle
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) src.push_back(DW'(8'h20 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    clr_logs();
    for (int i = 0; i < 40; i++) begin
      fe = i[0];
      cycle();
    end
    fe = 1'b0;
    chk("t3_all_once", 32'(count_ones(0, 39, 1)), 32'(12));

    // enable drop in steady streaming
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) src.push_back(DW'(8'h30 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (5) cycle();
    enable = 1'b0;
    clr_logs();
    repeat (6) cycle();
    chk("t4_words_after_drop", 32'(count_ones(0, 5, 1)), 32'(3));
    chk("t4_no_new_rd_en", 32'(count_ones(1, 5, 0)), 32'(0));
    chk("t4_busy_low", 32'(ln_b[4]), 32'(0));

    // reset mid-stream
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) src.push_back(DW'(8'h40 + i));
    enable = 1'b1;
    m_ready = 1'b1;
    clr_logs();
    repeat (4) cycle();
    chk("t5_valid_before", 32'(ln_v[3]), 32'(1));
    do_reset(1'b0);
    enable = 1'b1;
    m_ready = 1'b1;
    clr_logs();
    repeat (10) cycle();
    first = -1;
    for (int i = 0; i < ln_p.size(); i++)
      if (first < 0 && ln_p[i]) first = i;
    if (first < 0) fail_now("t5_no_word_after_reset");
    else chk("t5_first_after_reset", 32'(ln_d[first]), 32'(8'h43));

`ifdef FIFO_RD_CNT_EN
    do_reset(1'b1);
    for (int i = 0; i < 18; i++) src.push_back(DW'(i));
    enable = 1'b1;
    m_ready = 1'b1;
    repeat (30) cycle();
    chk("cnt_wrap_18", 32'(rd_count), 32'(2));
`endif

    // randomized run
    do_reset(1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1 && src.size() < 20)
        src.push_back(DW'($urandom));
      enable = ($urandom_range(7, 0) != 0);
      m_ready = ($urandom_range(2, 0) != 0);
      fe = ($urandom_range(4, 0) == 0);
      cycle();
    end
    enable = 1'b1;
    m_ready = 1'b1;
    fe = 1'b0;
    repeat (60) cycle();
    chk("rand_src_drained", 32'(src.size()), 32'(0));
    chk("rand_all_delivered", 32'(exp_order.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
